// File: rtl/tm1638_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : tm1638_responder_if
//  Purpose  : 3-wire TM1638 serial bus (cs, sck, split dio) between a bus
//             master and the TM1638 responder model.
//  Revision : 1.0 - initial release
// ============================================================================
interface tm1638_responder_if;
  logic cs;     // chip select, active low
  logic sck;    // serial clock, idle high
  logic dio_i;  // data master -> target
  logic dio_o;  // data target -> master
  logic dio_e;  // target drive enable for dio_o

  modport master (output cs, output sck, output dio_i, input dio_o, input dio_e);
  modport slave  (input cs, input sck, input dio_i, output dio_o, output dio_e);
endinterface
`default_nettype wire

// File: rtl/tm1638_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tm1638_responder
//  Purpose  : Clocked TM1638 LED & key target: decodes commands, holds the
//             16-byte display memory and brightness, answers key-scan reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tm1638_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_LED_BYTES = 16,
  parameter int IN_BYTES      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  tm1638_responder_if.slave          bus,
  input  logic [7:0]                 keys,
  output logic [NUM_LED_BYTES*8-1:0] mem_flat,
  output logic                       wr_strobe,
  output logic [3:0]                 wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       display_on,
  output logic [2:0]                 brightness,
  output logic                       frame_error
);

  localparam int c_RD_BITS = IN_BYTES * 8;
  localparam int c_RD_W    = $clog2(c_RD_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_IGNORE = 3'd4;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_dio_sync;
  logic                   r_cs_d, r_sck_d;
  logic [2:0]             r_state, w_next;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic [c_RD_W-1:0]      r_rd_cnt;
  logic [7:0]             r_keys;
  logic [3:0]             r_addr;
  logic                   r_auto_inc;
  logic                   r_dio_o, r_dio_e;

  logic w_cs_s, w_sck_s, w_dio_s;
  logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;
  logic [7:0] w_byte;
  logic w_byte_done, w_cmd_done, w_wr_done, w_rd_start, w_rd_fall, w_rd_last;
  logic w_key_bit;

  assign bus.dio_o = r_dio_o;
  assign bus.dio_e = r_dio_e;

  assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
  assign w_dio_s = r_dio_sync[SYNC_STAGES-1];

  // cs chain resets to "selected" so a reset inside a frame does not look
  // like a fresh cs falling edge; the rest of that frame is then ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_sync  <= '0;
      r_sck_sync <= '1;
      r_dio_sync <= '0;
      r_cs_d     <= 1'b0;
      r_sck_d    <= 1'b1;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
      r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], bus.dio_i};
      r_cs_d     <= w_cs_s;
      r_sck_d    <= w_sck_s;
    end
  end

  // Edge detection; a cs rise masks any sck edge seen in the same cycle.
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;
  assign w_sck_rise = w_sck_s & ~r_sck_d & ~w_cs_rise & (r_state != S_IDLE);
  assign w_sck_fall = ~w_sck_s & r_sck_d & ~w_cs_rise;
  assign w_byte     = {w_dio_s, r_shift[7:1]};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    if (w_cs_rise) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_next = S_CMD;
        S_CMD: begin
          if (w_cmd_done) begin
            case (w_byte[7:6])
              2'b01:   w_next = w_byte[1] ? S_READ : S_IGNORE;
              2'b11:   w_next = S_WRITE;
              default: w_next = S_IGNORE;
            endcase
          end
        end
        S_READ:  if (w_rd_last) w_next = S_IGNORE;
        default: w_next = r_state;
      endcase
    end
  end

  // Per-cycle actions derived from the current state and bus events.
  always_comb begin
    w_byte_done = w_sck_rise & (r_bit_cnt == 3'd7);
    w_cmd_done  = (r_state == S_CMD) & w_byte_done;
    w_wr_done   = (r_state == S_WRITE) & w_byte_done;
    w_rd_start  = w_cmd_done & (w_byte[7:6] == 2'b01) & w_byte[1];
    w_rd_fall   = (r_state == S_READ) & w_sck_fall;
    w_rd_last   = w_rd_fall & (r_rd_cnt == c_RD_W'(c_RD_BITS));
  end

  // Key byte i carries keys[i] in bit0 and keys[4+i] in bit4.
  always_comb begin
    w_key_bit = 1'b0;
    if (r_rd_cnt[2:0] == 3'd0)      w_key_bit = r_keys[{1'b0, r_rd_cnt[4:3]}];
    else if (r_rd_cnt[2:0] == 3'd4) w_key_bit = r_keys[{1'b1, r_rd_cnt[4:3]}];
  end

  // Shift register, command decode, memory writes and key-read driver.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_keys      <= '0;
      r_addr      <= '0;
      r_auto_inc  <= 1'b1;
      r_dio_o     <= 1'b0;
      r_dio_e     <= 1'b0;
      mem_flat    <= '0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      display_on  <= 1'b0;
      brightness  <= '0;
      frame_error <= 1'b0;
    end else begin
      wr_strobe   <= w_wr_done;
      frame_error <= w_cs_rise & (r_bit_cnt != 3'd0);

      if (w_cs_rise || (r_state == S_IDLE && w_cs_fall)) r_bit_cnt <= '0;
      else if (w_sck_rise)                               r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_sck_rise) r_shift <= w_byte;

      if (w_cmd_done) begin
        case (w_byte[7:6])
          2'b01: r_auto_inc <= ~w_byte[2];
          2'b11: r_addr     <= w_byte[3:0];
          2'b10: begin
            display_on <= w_byte[3];
            brightness <= w_byte[2:0];
          end
          default: ;
        endcase
      end else if (w_wr_done) begin
        mem_flat[{r_addr, 3'b000} +: 8] <= w_byte;
        wr_addr <= r_addr;
        wr_data <= w_byte;
        if (r_auto_inc) r_addr <= r_addr + 4'd1;
      end

      if (w_cs_rise) begin
        r_dio_e <= 1'b0;
      end else if (w_rd_start) begin
        r_dio_e  <= 1'b1;
        r_rd_cnt <= '0;
        r_keys   <= keys;
      end else if (w_rd_last) begin
        r_dio_e <= 1'b0;
      end else if (w_rd_fall) begin
        r_dio_o  <= w_key_bit;
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
